// File: rtl/program_loader.sv
// Program memory writer: packs UART bytes (high byte first) into DB-bit words and writes them from address 0.
// Latency: wr_en rises the cycle after the low-byte rx_done; a load ends on the HALT word or a full memory.
// Backpressure: none. The UART paces the stream, and rx_done strobes outside GET_HI/GET_LO (and CHECK) are dropped.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             one-cycle pulse that begins a load at address 0 (ignored while busy)
//   rx_data/rx_done   byte from the UART receiver and its one-cycle strobe
//   wr_en/wr_addr/wr_data   registered program memory write port, one strobe per word
//   busy, load_done, overflow, word_count   load status for the control unit
//   chk_err           (only with LOADER_CHECKSUM_EN) trailing checksum byte mismatch
//
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, a trailing XOR checksum
// byte is expected after the HALT word.
module program_loader #(
  parameter int AB = 11,
  parameter int DB = 16   // two bytes per word; only 16 is meaningful
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic          wr_en,
  output logic [AB-1:0] wr_addr,
  output logic [DB-1:0] wr_data,
  output logic          busy,
  output logic          load_done,
  output logic          overflow,
  output logic [AB:0]   word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic          chk_err
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_HI = 3'd1,
    GET_LO = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    CHECK  = 3'd5
  } state_t;

  // word_count can reach exactly 2^AB (a completely filled memory) and never more.
  localparam logic [AB:0] WC_MAX = {1'b1, {AB{1'b0}}};

`ifdef LOADER_CHECKSUM_EN
  localparam state_t HALT_NEXT = CHECK;
`else
  localparam state_t HALT_NEXT = DONE;
`endif

  state_t     state, state_n;
  logic [7:0] hi_byte;

  logic start_load;   // accepted start: only from IDLE or DONE
  logic take_hi;
  logic take_lo;
  logic in_write;
  logic addr_max;
  logic is_halt;
  logic ovf_exit;     // memory filled by a non-HALT word

  always_comb begin
    start_load = start && (state == IDLE || state == DONE);
    take_hi    = rx_done && (state == GET_HI);
    take_lo    = rx_done && (state == GET_LO);
    in_write   = (state == WRITE);
    addr_max   = &wr_addr;
    is_halt    = (wr_data == '0);
    ovf_exit   = in_write && !is_halt && addr_max;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_n = GET_HI;
      end
      GET_HI: begin
        if (rx_done) state_n = GET_LO;
      end
      GET_LO: begin
        if (rx_done) state_n = WRITE;
      end
      WRITE: begin
        // HALT wins over overflow: a HALT in the last slot is a normal finish.
        if (is_halt)       state_n = HALT_NEXT;
        else if (addr_max) state_n = DONE;
        else               state_n = GET_HI;
      end
      CHECK: begin
        if (rx_done) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs and datapath. Status flags are decoded from the next state so that
  // they change on the same edge as the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      hi_byte    <= 8'h00;
    end else begin
      wr_en     <= (state_n == WRITE);
      busy      <= (state_n != IDLE) && (state_n != DONE);
      load_done <= (state_n == DONE);

      if (start_load) begin
        wr_addr    <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
      end

      if (take_hi) hi_byte <= rx_data;
      if (take_lo) wr_data <= {hi_byte, rx_data};

      if (in_write) begin
        if (word_count != WC_MAX) word_count <= word_count + (AB+1)'(1);
        // The address parks on the last slot rather than wrapping onto word 0.
        if (!addr_max) wr_addr <= wr_addr + AB'(1);
        if (ovf_exit)  overflow <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_acc;

  // XOR of every program byte, HALT bytes included; compared against the byte after HALT.
  // An overflow exit never visits CHECK, so chk_err stays at its cleared value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_acc <= 8'h00;
      chk_err <= 1'b0;
    end else begin
      if (start_load) begin
        chk_acc <= 8'h00;
        chk_err <= 1'b0;
      end else if (take_hi || take_lo) begin
        chk_acc <= chk_acc ^ rx_data;
      end else if (rx_done && state == CHECK) begin
        chk_err <= (rx_data != chk_acc);
      end
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed-vector bench for program_loader: a default-size instance (AB=11) and a small
// instance (AB=3) share one byte stream; a monitor logs every write strobe of each.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_done;

  logic        wr_en, busy, load_done, overflow;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic [11:0] word_count;

  logic        s_wr_en, s_busy, s_load_done, s_overflow;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic [3:0]  s_word_count;

`ifdef LOADER_CHECKSUM_EN
  logic chk_err, s_chk_err;
`endif

  program_loader #(.AB(11), .DB(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_done(rx_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .load_done(load_done), .overflow(overflow), .word_count(word_count)
`ifdef LOADER_CHECKSUM_EN
    , .chk_err(chk_err)
`endif
  );

  program_loader #(.AB(3), .DB(16)) u_small (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_done(rx_done),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .busy(s_busy),
    .load_done(s_load_done), .overflow(s_overflow), .word_count(s_word_count)
`ifdef LOADER_CHECKSUM_EN
    , .chk_err(s_chk_err)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // Write log, sampled on the falling edge
  logic [10:0] w_addr_q[$];
  logic [15:0] w_data_q[$];
  int          w_cyc_q[$];
  logic [2:0]  s_addr_q[$];
  logic [15:0] s_data_q[$];
  int          b2b = 0;
  logic        prev_we = 1'b0;
  logic        s_prev_we = 1'b0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      w_addr_q.push_back(wr_addr);
      w_data_q.push_back(wr_data);
      w_cyc_q.push_back(cyc);
    end
    if (s_wr_en === 1'b1) begin
      s_addr_q.push_back(s_wr_addr);
      s_data_q.push_back(s_wr_data);
    end
    if ((wr_en === 1'b1 && prev_we) || (s_wr_en === 1'b1 && s_prev_we)) b2b++;
    prev_we   = (wr_en === 1'b1);
    s_prev_we = (s_wr_en === 1'b1);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    w_addr_q.delete();
    w_data_q.delete();
    w_cyc_q.delete();
    s_addr_q.delete();
    s_data_q.delete();
    b2b = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    idle(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One strobe followed by one quiet cycle (minimum legal spacing)
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle in which the low-byte strobe was driven
  task automatic send_word(input logic [15:0] w, output int lo_cyc);
    send_byte(w[15:8]);
    lo_cyc = cyc;
    send_byte(w[7:0]);
  endtask

  task automatic send_chk(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
    send_byte(b);
`else
    if (b == 8'hxx) send_byte(b);
`endif
  endtask

  task automatic test_reset();
    start = 1'b0; rx_done = 1'b0; rx_data = 8'h00; reset = 1'b1;
    idle(2);
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (wr_en !== 1'b0)       begin miscompares++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    vectors++; if (wr_addr !== 11'd0)    begin miscompares++; $display("FAIL rst_wr_addr got=%h exp=0", wr_addr); end
    vectors++; if (wr_data !== 16'h0)    begin miscompares++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vectors++; if (load_done !== 1'b0)   begin miscompares++; $display("FAIL rst_load_done got=%b exp=0", load_done); end
    vectors++; if (overflow !== 1'b0)    begin miscompares++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    vectors++; if (word_count !== 12'd0) begin miscompares++; $display("FAIL rst_word_count got=%0d exp=0", word_count); end
    vectors++; if (s_word_count !== 4'd0 || s_busy !== 1'b0) begin miscompares++; $display("FAIL rst_small got wc=%0d busy=%b exp 0/0", s_word_count, s_busy); end
`ifdef LOADER_CHECKSUM_EN
    vectors++; if (chk_err !== 1'b0)     begin miscompares++; $display("FAIL rst_chk_err got=%b exp=0", chk_err); end
`endif
    #1;
    reset = 1'b1;
    idle(2);
    clear_log();
  endtask

  task automatic test_basic();
    int lc;
    pulse_start();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got=%b exp=1", busy); end
    send_word(16'h0801, lc);
    send_word(16'h0000, lc);
    send_chk(8'h09);
    vectors++; if (w_addr_q.size() !== 2) begin miscompares++; $display("FAIL basic_nwrites got=%0d exp=2", w_addr_q.size()); end
    else begin
      vectors++; if (w_addr_q[0] !== 11'd0 || w_data_q[0] !== 16'h0801) begin miscompares++; $display("FAIL basic_w0 got=(%0d,%h) exp=(0,0801)", w_addr_q[0], w_data_q[0]); end
      vectors++; if (w_addr_q[1] !== 11'd1 || w_data_q[1] !== 16'h0000) begin miscompares++; $display("FAIL basic_w1 got=(%0d,%h) exp=(1,0000)", w_addr_q[1], w_data_q[1]); end
    end
    vectors++; if (load_done !== 1'b1)    begin miscompares++; $display("FAIL basic_load_done got=%b exp=1", load_done); end
    vectors++; if (word_count !== 12'd2)  begin miscompares++; $display("FAIL basic_word_count got=%0d exp=2", word_count); end
    vectors++; if (overflow !== 1'b0)     begin miscompares++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
    vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    vectors++; if (b2b !== 0)             begin miscompares++; $display("FAIL basic_b2b got=%0d exp=0", b2b); end
  endtask

  task automatic test_full_program();
    logic [15:0] prog [8] = '{16'h0801, 16'h1002, 16'h1803, 16'h2004,
                              16'h2805, 16'h3006, 16'h3807, 16'h0000};
    int lo_cyc [8];
    do_reset();
    clear_log();
    pulse_start();
    for (int i = 0; i < 8; i++) send_word(prog[i], lo_cyc[i]);
    send_chk(8'h00);
    vectors++; if (w_addr_q.size() !== 8) begin miscompares++; $display("FAIL full_nwrites got=%0d exp=8", w_addr_q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (w_addr_q[i] !== 11'(i) || w_data_q[i] !== prog[i] || w_cyc_q[i] !== lo_cyc[i] + 1) begin
          miscompares++;
          $display("FAIL full_w%0d got=(%0d,%h,cyc %0d) exp=(%0d,%h,cyc %0d)", i,
                   w_addr_q[i], w_data_q[i], w_cyc_q[i], i, prog[i], lo_cyc[i] + 1);
        end
      end
    end
    vectors++; if (load_done !== 1'b1 || word_count !== 12'd8 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL full_status got done=%b wc=%0d ovf=%b exp 1/8/0", load_done, word_count, overflow); end
    vectors++; if (b2b !== 0) begin miscompares++; $display("FAIL full_b2b got=%0d exp=0", b2b); end
  endtask

  task automatic test_overflow();
    int lc;
    logic [15:0] w;
    do_reset();
    clear_log();
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      w = {8'(8'h10 + i), 8'(8'h20 + i)};
      send_word(w, lc);
    end
    vectors++; if (s_addr_q.size() !== 8) begin miscompares++; $display("FAIL ovf_nwrites got=%0d exp=8", s_addr_q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        w = {8'(8'h10 + i), 8'(8'h20 + i)};
        vectors++;
        if (s_addr_q[i] !== 3'(i) || s_data_q[i] !== w) begin
          miscompares++; $display("FAIL ovf_w%0d got=(%0d,%h) exp=(%0d,%h)", i, s_addr_q[i], s_data_q[i], i, w);
        end
      end
    end
    vectors++; if (s_load_done !== 1'b1) begin miscompares++; $display("FAIL ovf_load_done got=%b exp=1", s_load_done); end
    vectors++; if (s_overflow !== 1'b1)  begin miscompares++; $display("FAIL ovf_overflow got=%b exp=1", s_overflow); end
    vectors++; if (s_word_count !== 4'd8) begin miscompares++; $display("FAIL ovf_word_count got=%0d exp=8", s_word_count); end
    vectors++; if (s_wr_addr !== 3'd7 || s_busy !== 1'b0) begin miscompares++; $display("FAIL ovf_park got addr=%0d busy=%b exp 7/0", s_wr_addr, s_busy); end
`ifdef LOADER_CHECKSUM_EN
    vectors++; if (s_chk_err !== 1'b0) begin miscompares++; $display("FAIL ovf_chk_err got=%b exp=0", s_chk_err); end
`endif
  endtask

  task automatic test_reset_midload();
    int lc;
    do_reset();
    clear_log();
    pulse_start();
    send_byte(8'h08);
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || wr_en !== 1'b0 || word_count !== 12'd0) begin
      miscompares++; $display("FAIL midrst_clear got busy=%b we=%b wc=%0d exp 0/0/0", busy, wr_en, word_count); end
    reset = 1'b1;
    idle(1);
    send_byte(8'h01);   // IDLE: must be dropped
    vectors++; if (w_addr_q.size() !== 0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL midrst_nowrite got writes=%0d busy=%b exp 0/0", w_addr_q.size(), busy); end
    pulse_start();
    send_word(16'h0801, lc);
    send_word(16'h0000, lc);
    send_chk(8'h09);
    vectors++; if (w_addr_q.size() !== 2) begin miscompares++; $display("FAIL midrst_nwrites got=%0d exp=2", w_addr_q.size()); end
    else begin
      vectors++; if (w_addr_q[0] !== 11'd0 || w_data_q[0] !== 16'h0801) begin
        miscompares++; $display("FAIL midrst_w0 got=(%0d,%h) exp=(0,0801)", w_addr_q[0], w_data_q[0]); end
    end
    vectors++; if (load_done !== 1'b1 || word_count !== 12'd2) begin
      miscompares++; $display("FAIL midrst_done got done=%b wc=%0d exp 1/2", load_done, word_count); end
  endtask

  task automatic test_ignored_inputs();
    int lc;
    clear_log();
    send_byte(8'h55);   // DONE: rx_done ignored
    send_byte(8'h66);
    vectors++; if (w_addr_q.size() !== 0 || load_done !== 1'b1 || word_count !== 12'd2 || busy !== 1'b0) begin
      miscompares++; $display("FAIL ign_done got writes=%0d done=%b wc=%0d busy=%b exp 0/1/2/0",
                              w_addr_q.size(), load_done, word_count, busy); end
    pulse_start();
    vectors++; if (load_done !== 1'b0 || word_count !== 12'd0 || wr_addr !== 11'd0) begin
      miscompares++; $display("FAIL ign_restart got done=%b wc=%0d addr=%0d exp 0/0/0", load_done, word_count, wr_addr); end
    send_byte(8'h12);
    pulse_start();      // busy: must not restart or re-arm the high byte
    send_byte(8'h34);
    vectors++; if (w_addr_q.size() !== 1) begin miscompares++; $display("FAIL ign_busy_nwrites got=%0d exp=1", w_addr_q.size()); end
    else begin
      vectors++; if (w_addr_q[0] !== 11'd0 || w_data_q[0] !== 16'h1234) begin
        miscompares++; $display("FAIL ign_busy_w0 got=(%0d,%h) exp=(0,1234)", w_addr_q[0], w_data_q[0]); end
    end
    send_word(16'h0000, lc);
    send_chk(8'h26);
    vectors++; if (w_addr_q.size() !== 2 || load_done !== 1'b1 || word_count !== 12'd2) begin
      miscompares++; $display("FAIL ign_end got writes=%0d done=%b wc=%0d exp 2/1/2", w_addr_q.size(), load_done, word_count); end
`ifdef LOADER_CHECKSUM_EN
    vectors++; if (chk_err !== 1'b0) begin miscompares++; $display("FAIL ign_chk_err got=%b exp=0", chk_err); end
`endif
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int lc;
    do_reset();
    pulse_start();
    send_word(16'h0801, lc);
    send_word(16'h0000, lc);
    vectors++; if (load_done !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL chk_wait got done=%b busy=%b exp 0/1", load_done, busy); end
    send_byte(8'h09);
    vectors++; if (chk_err !== 1'b0 || load_done !== 1'b1) begin
      miscompares++; $display("FAIL chk_good got err=%b done=%b exp 0/1", chk_err, load_done); end
    pulse_start();
    send_word(16'h0801, lc);
    send_word(16'h0000, lc);
    send_byte(8'h0A);
    vectors++; if (chk_err !== 1'b1 || load_done !== 1'b1) begin
      miscompares++; $display("FAIL chk_bad got err=%b done=%b exp 1/1", chk_err, load_done); end
    pulse_start();
    vectors++; if (chk_err !== 1'b0) begin miscompares++; $display("FAIL chk_clear got=%b exp=0", chk_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full_program();
    test_overflow();
    test_reset_midload();
    test_ignored_inputs();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
